clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel, runtime-programmable clock-enable and tick generator.
- Parametrised successor to the fixed-divisor divider used for mclk generation at top level.
- Produces per-channel single-cycle tick pulses and divided square levels from one system clock; all outputs are enables, never new clock nets.
- Sits beside the PLL in the top level. Feeds timers, UART baud and LED blink logic; divisors are written through the com block register path.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- WIDTH, 28, divisor and counter width in bits.
- DEFAULT_DIV, 2, divisor loaded into every channel at reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel of the write.
- cfg_div  in  WIDTH  new divisor, unsigned.
- cfg_oneshot  in  1  mode for the write: 0 periodic, 1 one-shot.
- en  in  CHANNELS  per-channel run enable, level-sensitive.
- sync  in  1  phase-align strobe for all channels.
- tick  out  CHANNELS  registered one-cycle pulse per period.
- level  out  CHANNELS  registered divided square wave.
- done  out  CHANNELS  one-shot channel has fired and is halted.

Behaviour:
- **Divisor clamp:** div_eff = (div == 0) ? 1 : div. Counter is WIDTH bits, range 0..div_eff-1.
- **Reset** (async, rst_n low):
  - div = DEFAULT_DIV, mode = periodic, count = 0.
  - tick = 0, done = 0, level = (0 >= DEFAULT_DIV>>1).
- **Run condition:** channel runs when en[i] = 1 and done[i] = 0.
- **On a running cycle:**
  - If count == div_eff-1: count <= 0 and tick <= 1. Otherwise count <= count+1 and tick <= 0.
  - level <= (count_next >= div_eff>>1).
  - div=4 gives level 0,0,1,1; div=1 gives level constant 1 and tick every cycle.
- **Not running:** count and level hold; tick <= 0.
- **First-tick latency:** the first tick is high in the cycle following the div_eff-th running edge after count = 0.
- **One-shot mode:** on the edge that asserts tick, done[i] <= 1. The channel then halts with count = 0. done clears only on a config write to that channel, on sync, or on reset.
- **Config write:** cfg_we with cfg_ch >= CHANNELS is ignored. Otherwise, for channel cfg_ch:
  - mode <= cfg_oneshot; done <= 0.
  - Divisor update timing follows the Optional Feature section.
- **sync** (all channels, overrides en on the same edge):
  - count <= 0, tick <= 0, done <= 0.
  - level <= (0 >= div_eff>>1), using the divisor in effect after that edge.
- **Simultaneous sync and cfg_we:** both apply. The new divisor and mode take effect, and the counter restarts at 0.
- **Simultaneous cfg_we and wrap on the same channel:** the write wins and tick is still emitted for that wrap.
- **Wrap-around:** counting never overflows WIDTH, because count < div_eff <= 2^WIDTH-1.
- **Mid-operation reset:** asynchronous, returns every register to its reset value immediately. No pending state survives.

Optional Feature:
- Macro: CLKDIV_GLITCHLESS_EN.
- Defined:
  - cfg_div goes into a per-channel shadow register with a pending flag.
  - The shadow is applied on the edge where count wraps to 0, or immediately if the channel is not running, or on sync.
  - The counter is not disturbed, so no truncated or stretched period is ever emitted.
  - A second write before apply overwrites the shadow.
- Undefined:
  - cfg_div is applied on the write edge and that channel's count <= 0.
  - level is recomputed from the new divisor; the in-flight period is abandoned.

Decomposition:
- Package clk_div_pkg:
  - typedef enum logic {DIV_PERIODIC, DIV_ONESHOT} div_mode_t.
  - function div_eff(div) implementing the clamp.
  - localparam DIV_MIN = 1.
- One sub-module, clk_div_chan: per-channel counter, mode, done, shadow and tick/level registers. Instantiated CHANNELS times in a generate loop.
- Top-level clk_div_multi decodes cfg_ch and fans out sync.

Test Plan:
1. Reset, en=4'b0001, DEFAULT_DIV=2 -> tick[0] pulses every 2 cycles with the first pulse 2 cycles after en; level[0] toggles 0,1; other channels tick=0.
2. Write ch1 div=5 periodic, en[1]=1 -> tick[1] period 5; level[1] = 0,0,1,1,1 repeating; div=0 write -> tick every cycle, level constant 1.
3. Write ch2 div=3 one-shot, en[2]=1 -> exactly one tick after 3 cycles; done[2]=1 and no further ticks; a new write clears done and rearms.
4. Channels 0..3 running at divs 2,3,4,7, pulse sync mid-period -> all counters 0; all ticks coincide 84 cycles (LCM) after the sync edge; the sync cycle has no tick.
5. ch0 div=8 running, write div=4 at count=5:
   - Without macro: next tick 4 cycles after the write.
   - With CLKDIV_GLITCHLESS_EN: tick at original wrap (3 cycles), then period 4.
6. Deassert rst_n mid-count with en held -> all outputs at reset values immediately; counting restarts from 0 with div=DEFAULT_DIV after release; cfg_ch=CHANNELS write ignored.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock-enable divider.
// The optional CLKDIV_GLITCHLESS_EN feature is handled in clk_div_chan.
package clk_div_pkg;

    typedef enum logic {
        DIV_PERIODIC = 1'b0,
        DIV_ONESHOT  = 1'b1
    } div_mode_t;

    localparam int DIV_MIN   = 1;
    localparam int DIV_W_MAX = 32;

    // A divisor of zero behaves as divide-by-one.
    function automatic logic [DIV_W_MAX-1:0] div_eff(input logic [DIV_W_MAX-1:0] div);
        return (div == '0) ? DIV_W_MAX'(DIV_MIN) : div;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, mode, done flag and registered tick/level.
// Macro CLKDIV_GLITCHLESS_EN: divisor writes go to a shadow register and are
// applied only at a period boundary, while idle, or on sync.
// WIDTH is limited to 32 bits by the package helper.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             cfg_we_i,
    input  logic [WIDTH-1:0] cfg_div_i,
    input  logic             cfg_oneshot_i,
    output logic             tick_o,
    output logic             level_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] DEF_DIV   = WIDTH'(DEFAULT_DIV);
    localparam logic             LEVEL_RST = ((DEFAULT_DIV >> 1) == 0);

    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] count_q, count_d;
    div_mode_t        mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             level_q, level_d;
    logic             done_q, done_d;
`ifdef CLKDIV_GLITCHLESS_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
`endif

    logic [WIDTH-1:0] divEff;
    logic             running;
    logic             wrapNow;

    function automatic logic [WIDTH-1:0] effOf(input logic [WIDTH-1:0] d);
        return WIDTH'(div_eff(DIV_W_MAX'(d)));
    endfunction

    function automatic logic levelAtZero(input logic [WIDTH-1:0] d);
        return ((effOf(d) >> 1) == '0);
    endfunction

    // Next-state: run/wrap first, then config write, then sync has the final say.
    always_comb begin
        div_d   = div_q;
        mode_d  = mode_q;
        count_d = count_q;
        tick_d  = 1'b0;
        level_d = level_q;
        done_d  = done_q;
`ifdef CLKDIV_GLITCHLESS_EN
        shadow_d = shadow_q;
        pend_d   = pend_q;
`endif
        divEff  = effOf(div_q);
        running = en_i && !done_q;
        // >= rather than == so a count left above a shrunken divisor still wraps.
        wrapNow = running && (count_q >= (divEff - WIDTH'(1)));

        if (running) begin
            if (wrapNow) begin
                count_d = '0;
                tick_d  = 1'b1;
                if (mode_q == DIV_ONESHOT) begin
                    done_d = 1'b1;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
            level_d = (count_d >= (divEff >> 1));
        end

        if (cfg_we_i) begin
            mode_d = div_mode_t'(cfg_oneshot_i);
            done_d = 1'b0;
`ifdef CLKDIV_GLITCHLESS_EN
            shadow_d = cfg_div_i;
            pend_d   = 1'b1;
`else
            div_d   = cfg_div_i;
            count_d = '0;
            level_d = levelAtZero(cfg_div_i);
`endif
        end

`ifdef CLKDIV_GLITCHLESS_EN
        if (pend_d && (wrapNow || !running || sync_i)) begin
            div_d  = shadow_d;
            pend_d = 1'b0;
            if (wrapNow) begin
                level_d = levelAtZero(shadow_d);
            end
        end
`endif

        if (sync_i) begin
            count_d = '0;
            tick_d  = 1'b0;
            done_d  = 1'b0;
            level_d = levelAtZero(div_d);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= DEF_DIV;
            mode_q  <= DIV_PERIODIC;
            count_q <= '0;
            tick_q  <= 1'b0;
            level_q <= LEVEL_RST;
            done_q  <= 1'b0;
`ifdef CLKDIV_GLITCHLESS_EN
            shadow_q <= DEF_DIV;
            pend_q   <= 1'b0;
`endif
        end else begin
            div_q   <= div_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            level_q <= level_d;
            done_q  <= done_d;
`ifdef CLKDIV_GLITCHLESS_EN
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
`endif
        end
    end

    assign tick_o  = tick_q;
    assign level_o = level_q;
    assign done_o  = done_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable tick / clock-enable generator.
// Decodes the config write to one channel and fans sync out to all channels.
// Optional macro CLKDIV_GLITCHLESS_EN selects boundary-aligned divisor updates.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                cfg_we,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]                                    cfg_div,
    input  logic                                                cfg_oneshot,
    input  logic [CHANNELS-1:0]                                 en,
    input  logic                                                sync,
    output logic [CHANNELS-1:0]                                 tick,
    output logic [CHANNELS-1:0]                                 level,
    output logic [CHANNELS-1:0]                                 done
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Channel numbers at or above CHANNELS match no instance, so such writes vanish.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic chWe;
        assign chWe = cfg_we && (cfg_ch == CH_W'(i));

        clk_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .en_i          (en[i]),
            .sync_i        (sync),
            .cfg_we_i      (chWe),
            .cfg_div_i     (cfg_div),
            .cfg_oneshot_i (cfg_oneshot),
            .tick_o        (tick[i]),
            .level_o       (level[i]),
            .done_o        (done[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_clk_div_multi;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [27:0] cfg_div;
    logic        cfg_oneshot;
    logic [3:0]  en;
    logic        sync;
    logic [3:0]  tick;
    logic [3:0]  level;
    logic [3:0]  done;

    int cyc    = 0;
    int checks = 0;
    int fails  = 0;
    int divs[4] = '{2, 3, 4, 7};

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] tickExp;
        logic [3:0] tickMask;
        logic [3:0] levelExp;
        logic [3:0] levelMask;
        logic [3:0] doneExp;
        logic [3:0] doneMask;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;

    clk_div_multi #(
        .CHANNELS    (4),
        .WIDTH       (28),
        .DEFAULT_DIV (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
        .en          (en),
        .sync        (sync),
        .tick        (tick),
        .level       (level),
        .done        (done)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic pushExp(input int c, input string name,
                           input logic [3:0] tE, input logic [3:0] tM,
                           input logic [3:0] lE, input logic [3:0] lM,
                           input logic [3:0] dE, input logic [3:0] dM);
        exp_t e;
        e.cyc = c; e.name = name;
        e.tickExp = tE;  e.tickMask = tM;
        e.levelExp = lE; e.levelMask = lM;
        e.doneExp = dE;  e.doneMask = dM;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] enV, input logic syncV);
        en   = enV;
        sync = syncV;
    endtask

    task automatic cfgWrite(input logic [1:0] ch, input logic [27:0] dv, input logic os);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_oneshot = os;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare every expectation due at this cycle against the outputs.
    always @(negedge clk) begin
        if (rst_n) begin
            while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                monE = expQ.pop_front();
                if (monE.cyc != cyc) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL %s stale entry got_cyc=%0d want_cyc=%0d", monE.name, cyc, monE.cyc);
                end else begin
                    if (monE.tickMask != 4'b0)
                        checkOutput({monE.name, ".tick"}, tick & monE.tickMask, monE.tickExp & monE.tickMask);
                    if (monE.levelMask != 4'b0)
                        checkOutput({monE.name, ".level"}, level & monE.levelMask, monE.levelExp & monE.levelMask);
                    if (monE.doneMask != 4'b0)
                        checkOutput({monE.name, ".done"}, done & monE.doneMask, monE.doneExp & monE.doneMask);
                end
            end
        end
    end

    initial begin
        int n;
        logic [3:0] tE;
        logic [3:0] lE;
        logic       hit;

        rst_n = 1'b1; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 28'd0; cfg_oneshot = 1'b0;
        en = 4'b0; sync = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_tick", tick, 4'b0000);
        checkOutput("reset_level", level, 4'b0000);
        checkOutput("reset_done", done, 4'b0000);
        waitNeg(2);
        rst_n = 1'b1;

        // Test 1: default divisor 2 on channel 0.
        waitNeg(1);
        n = cyc;
        applyStimulus(4'b0001, 1'b0);
        for (int k = 1; k <= 8; k++)
            pushExp(n + k, "t1_div2", (k % 2 == 0) ? 4'b0001 : 4'b0000, 4'b1111,
                    (k % 2 == 1) ? 4'b0001 : 4'b0000, 4'b0001, 4'b0000, 4'b1111);
        waitNeg(9);

        // Test 2: channel 1 divide-by-5, then divide-by-0 (acts as 1).
        cfgWrite(2'd1, 28'd5, 1'b0);
        n = cyc;
        applyStimulus(4'b0011, 1'b0);
        for (int k = 1; k <= 10; k++)
            pushExp(n + k, "t2_div5", (k % 5 == 0) ? 4'b0010 : 4'b0000, 4'b0010,
                    ((k % 5) >= 2) ? 4'b0010 : 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        waitNeg(11);
        applyStimulus(4'b0001, 1'b0);
        waitNeg(1);
        cfgWrite(2'd1, 28'd0, 1'b0);
        n = cyc;
        applyStimulus(4'b0011, 1'b0);
        for (int k = 1; k <= 4; k++)
            pushExp(n + k, "t2_div0", 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        waitNeg(5);

        // Test 3: channel 2 one-shot divide-by-3, then rearm.
        cfgWrite(2'd2, 28'd3, 1'b1);
        n = cyc;
        applyStimulus(4'b0111, 1'b0);
        for (int k = 1; k <= 6; k++)
            pushExp(n + k, "t3_shot", (k == 3) ? 4'b0100 : 4'b0000, 4'b0100,
                    4'b0000, 4'b0000, (k >= 3) ? 4'b0100 : 4'b0000, 4'b0100);
        waitNeg(7);
        n = cyc;
        for (int k = 1; k <= 5; k++)
            pushExp(n + k, "t3_rearm", (k == 4) ? 4'b0100 : 4'b0000, 4'b0100,
                    4'b0000, 4'b0000, (k >= 4) ? 4'b0100 : 4'b0000, 4'b0100);
        cfgWrite(2'd2, 28'd3, 1'b1);
        waitNeg(5);

        // Test 4: divisors 2,3,4,7 aligned by sync; all tick together 84 cycles later.
        applyStimulus(4'b0000, 1'b0);
        waitNeg(1);
        cfgWrite(2'd0, 28'd2, 1'b0);
        cfgWrite(2'd1, 28'd3, 1'b0);
        cfgWrite(2'd2, 28'd4, 1'b0);
        cfgWrite(2'd3, 28'd7, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        waitNeg(11);
        n = cyc;
        for (int k = 0; k <= 85; k++) begin
            tE = 4'b0;
            lE = 4'b0;
            for (int i = 0; i < 4; i++) begin
                tE[i] = (k > 0) && (k % divs[i] == 0);
                lE[i] = (k % divs[i]) >= (divs[i] / 2);
            end
            pushExp(n + 1 + k, (k == 84) ? "t4_lcm" : "t4_sync", tE, 4'b1111, lE, 4'b1111, 4'b0000, 4'b1111);
        end
        applyStimulus(4'b1111, 1'b1);
        waitNeg(1);
        applyStimulus(4'b1111, 1'b0);
        waitNeg(86);

        // Test 5: channel 0 divide-by-8 retuned to 4 while count is 5.
        applyStimulus(4'b0000, 1'b0);
        waitNeg(1);
        cfgWrite(2'd0, 28'd8, 1'b0);
        applyStimulus(4'b0000, 1'b1);
        waitNeg(1);
        n = cyc;
        applyStimulus(4'b0001, 1'b0);
        waitNeg(5);
        for (int c = n + 6; c <= n + 15; c++) begin
`ifdef CLKDIV_GLITCHLESS_EN
            hit = (c == n + 8) || (c == n + 12);
`else
            hit = (c == n + 10) || (c == n + 14);
`endif
            pushExp(c, "t5_retune", hit ? 4'b0001 : 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        cfgWrite(2'd0, 28'd4, 1'b0);
        waitNeg(10);

        // Test 6: asynchronous reset mid-count, then restart at the default divisor.
        waitNeg(3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_tick", tick, 4'b0000);
        checkOutput("t6_rst_level", level, 4'b0000);
        checkOutput("t6_rst_done", done, 4'b0000);
        waitNeg(2);
        rst_n = 1'b1;
        n = cyc;
        for (int k = 1; k <= 6; k++)
            pushExp(n + k, "t6_restart", (k % 2 == 0) ? 4'b0001 : 4'b0000, 4'b1111,
                    (k % 2 == 1) ? 4'b0001 : 4'b0000, 4'b0001, 4'b0000, 4'b1111);
        waitNeg(7);

        for (int t = 0; t < 200 && expQ.size() > 0; t++) @(negedge clk);
        if (expQ.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain got_pending=%0d want_pending=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
